// File: rtl/pe_link_tx.sv
// Packs four 32-bit stream beats into one 130-bit link word and advances in
// lockstep with ap_start. Optional partial-word flush: PE_LINK_TX_TIMEOUT_EN.
module pe_link_tx #(
    parameter int LINK_WIDTH = 130,
    parameter int IN_WIDTH   = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [LINK_WIDTH-1:0] out_to_north,
    output logic [15:0]           words_sent,
    output logic                  busy
);
    localparam int LANES = 128 / IN_WIDTH;
    localparam int CW    = $clog2(LANES);

    logic [LANES-1:0][IN_WIDTH-1:0] lanes_q, lanes_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [LINK_WIDTH-1:0]          out_q, out_d;
    logic [15:0]                    words_q, words_d;
    logic                           busy_q, busy_d;
`ifdef PE_LINK_TX_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);
    logic [15:0]                    idle_q, idle_d;
`endif

    assign in_ready     = ap_start;
    assign out_to_north = out_q;
    assign words_sent   = words_q;
    assign busy         = busy_q;

    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        words_d = words_q;
`ifdef PE_LINK_TX_TIMEOUT_EN
        idle_d  = idle_q;
`endif
        // With ap_start low everything holds so the chain never skips or repeats a word.
        if (ap_start) begin
            out_d[129:128] = 2'b00;
            if (in_valid) begin
                lanes_d[cnt_q] = in_data;
                if (cnt_q == CW'(LANES - 1) || in_last) begin
                    // Unwritten upper lanes are already zero, cleared at the previous completion.
                    out_d   = {in_last, 1'b1, lanes_d};
                    lanes_d = '0;
                    cnt_d   = '0;
                    words_d = words_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`ifdef PE_LINK_TX_TIMEOUT_EN
                idle_d = '0;
            end else if (cnt_q != '0) begin
                if (idle_q == IDLE_LAST) begin
                    out_d   = {1'b0, 1'b1, lanes_q};
                    lanes_d = '0;
                    cnt_d   = '0;
                    words_d = words_q + 16'd1;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end else begin
                idle_d = '0;
`endif
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
`ifdef PE_LINK_TX_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            words_q <= words_d;
            busy_q  <= busy_d;
`ifdef PE_LINK_TX_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end
endmodule

// File: tb/tb_pe_link_tx.sv
// Bench for pe_link_tx: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_pe_link_tx;
    logic         clk = 1'b0;
    logic         reset;
    logic         ap_start;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [129:0] out_to_north;
    logic [15:0]  words_sent;
    logic         busy;

    int n_checks = 0;
    int n_err    = 0;

    pe_link_tx #(.LINK_WIDTH(130), .IN_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_to_north(out_to_north), .words_sent(words_sent), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending beats in a queue, word formed from the queue contents.
    logic [31:0]  pend[$];
    logic [129:0] m_out;
    logic [15:0]  m_words;
    int           m_idle;

    task automatic emit(input logic last);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < pend.size(); i++) p[32*i +: 32] = pend[i];
        m_out = {last, 1'b1, p};
        pend.delete();
        m_words = m_words + 16'd1;
        m_idle = 0;
    endtask

    initial begin
        m_out = '0; m_words = '0; m_idle = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                pend.delete(); m_out = '0; m_words = '0; m_idle = 0;
            end else if (ap_start) begin
                m_out[129:128] = 2'b00;
                if (in_valid) begin
                    pend.push_back(in_data);
                    m_idle = 0;
                    if (pend.size() == 4 || in_last) emit(in_last);
                end else if (pend.size() != 0) begin
`ifdef PE_LINK_TX_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == 16) emit(1'b0);
`endif
                end else begin
                    m_idle = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_out", out_to_north, m_out);
            chk("model_words", 130'(words_sent), 130'(m_words));
            chk("model_busy", 130'(busy), 130'(pend.size() != 0));
            chk("model_ready", 130'(in_ready), 130'(ap_start));
        end
    end

    task automatic step(input logic ap, input logic v, input logic [31:0] d, input logic l);
        #1;
        ap_start = ap; in_valid = v; in_data = d; in_last = l;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ap_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", out_to_north, '0);
        chk("rst_words", 130'(words_sent), 130'd0);
        chk("rst_busy", 130'(busy), 130'd0);
        #2 reset = 1'b0;

        // Four-beat word
        step(1, 1, 32'h11, 0);
        step(1, 1, 32'h22, 0);
        step(1, 1, 32'h33, 0);
        step(1, 1, 32'h44, 0);
        chk("w4_out", out_to_north, {2'b01, 128'h00000044_00000033_00000022_00000011});
        chk("w4_words", 130'(words_sent), 130'd1);
        step(1, 0, 32'h0, 0);
        chk("w4_drop", 130'(out_to_north[129:128]), 130'd0);
        chk("w4_hold_payload", 130'(out_to_north[127:0]), 130'h00000044_00000033_00000022_00000011);

        // Short message ended by in_last
        step(1, 1, 32'hA, 0);
        chk("short_busy", 130'(busy), 130'd1);
        step(1, 1, 32'hB, 1);
        chk("short_out", out_to_north, {2'b11, 128'h0000000B_0000000A});
        chk("short_busy0", 130'(busy), 130'd0);

        // ap_start low holds the emitted word
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'hDEAD0000 + i, 1);
            chk("stall_ready", 130'(in_ready), 130'd0);
            chk("stall_valid", 130'(out_to_north[128]), 130'd1);
        end
        chk("stall_words", 130'(words_sent), 130'd2);
        step(1, 0, 32'h0, 0);
        chk("stall_release", 130'(out_to_north[128]), 130'd0);

        // Back-to-back single-beat messages
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'hC0 + i, 1);
            chk("b2b_out", out_to_north, {2'b11, 96'h0, 32'hC0 + i});
        end

`ifdef PE_LINK_TX_TIMEOUT_EN
        step(1, 1, 32'h55, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 32'h0, 0);
        chk("to_pending", 130'(busy), 130'd1);
        chk("to_pending_v", 130'(out_to_north[128]), 130'd0);
        step(1, 0, 32'h0, 0);
        chk("to_flush", out_to_north, {2'b01, 128'h55});
        chk("to_busy0", 130'(busy), 130'd0);
        step(1, 1, 32'h66, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 32'h0, 0);
        step(1, 1, 32'h77, 0);
        chk("to_beat_wins_v", 130'(out_to_north[128]), 130'd0);
        chk("to_beat_wins_busy", 130'(busy), 130'd1);
        step(1, 1, 32'h88, 1);
        chk("to_after", out_to_north, {2'b11, 128'h00000088_00000077_00000066});
`endif

        // Asynchronous reset with two lanes packed
        step(1, 1, 32'hE1, 0);
        step(1, 1, 32'hE2, 0);
        chk("pre_rst_busy", 130'(busy), 130'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_out", out_to_north, '0);
        chk("arst_words", 130'(words_sent), 130'd0);
        chk("arst_busy", 130'(busy), 130'd0);
        ap_start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        step(1, 1, 32'hF1, 0);
        step(1, 1, 32'hF2, 0);
        step(1, 1, 32'hF3, 0);
        step(1, 1, 32'hF4, 0);
        chk("post_rst_out", out_to_north, {2'b01, 128'h000000F4_000000F3_000000F2_000000F1});
        chk("post_rst_words", 130'(words_sent), 130'd1);

        // Wrap the word counter
        for (int i = 0; i < 65534; i++) step(1, 1, i, 1);
        chk("wrap_ffff", 130'(words_sent), 130'hFFFF);
        step(1, 1, 32'h12345678, 1);
        chk("wrap_zero", 130'(words_sent), 130'd0);
        chk("wrap_out", out_to_north, {2'b11, 96'h0, 32'h12345678});

        step(1, 0, 32'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
